// File: rtl/seq_alu.sv
// seq_alu: valid/ready handshaked ALU; single-cycle ops go IDLE->DONE.
// Define SEQ_ALU_MUL_EN to build the shift-add multiplier (opcode 101) and BUSY state.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       operation_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             overflow_o
);

`ifdef SEQ_ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_ovf;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic             w_accept;
    logic             w_load;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;

    assign w_accept = valid_i && (r_state == S_IDLE);
    assign w_sum    = {1'b0, a_i} + {1'b0, b_i};
    assign w_diff   = {1'b0, a_i} - {1'b0, b_i};

`ifdef SEQ_ALU_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_is_mul;
    logic             w_last;

    assign w_is_mul   = (operation_i == 3'b101);
    assign w_load     = w_accept && !w_is_mul;
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    // one multiplier bit per BUSY cycle; partial product kept mod 2^WIDTH
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (w_accept && w_is_mul) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= a_i;
            r_mplier <= b_i;
        end else if (r_state == S_BUSY) begin
            r_cnt    <= r_cnt + CW'(1);
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end
`else
    assign w_load = w_accept;
`endif

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (operation_i)
            3'b000: w_res = a_i & b_i;
            3'b001: w_res = a_i | b_i;
            3'b011: w_res = a_i ^ b_i;
            3'b010: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            3'b110: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            3'b111: w_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            3'b100: begin
                if (32'(b_i) < WIDTH) begin
                    w_res = a_i << b_i;
                end
            end
            default: w_res = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (valid_i) begin
`ifdef SEQ_ALU_MUL_EN
                    w_next = w_is_mul ? S_BUSY : S_DONE;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef SEQ_ALU_MUL_EN
            S_BUSY: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (ready_i) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_load) begin
            r_result <= w_res;
            r_carry  <= w_carry;
            r_ovf    <= w_ovf;
`ifdef SEQ_ALU_MUL_EN
        end else if ((r_state == S_BUSY) && w_last) begin
            r_result <= w_acc_next;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end
    end

    assign ready_o    = (r_state == S_IDLE);
    assign valid_o    = (r_state == S_DONE);
    assign result_o   = r_result;
    assign zero_o     = (r_result == '0);
    assign carry_o    = r_carry;
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: random + directed stimulus against an arithmetic reference model.
// Honours SEQ_ALU_MUL_EN the same way the design does.
module tb_seq_alu;
    localparam int W = 8;
    localparam longint FULL = 64'd1 << W;
    localparam longint HALF = 64'd1 << (W - 1);

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic [2:0]   operation_i = '0;
    logic         valid_o;
    logic         ready_i = 1'b0;
    logic [W-1:0] result_o;
    logic         zero_o;
    logic         carry_o;
    logic         overflow_o;

    int n_checks = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i),
        .ready_o(ready_o), .a_i(a_i), .b_i(b_i),
        .operation_i(operation_i), .valid_o(valid_o),
        .ready_i(ready_i), .result_o(result_o), .zero_o(zero_o),
        .carry_o(carry_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input longint got,
                       input longint exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // returns {overflow, carry, result}
    function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [2:0] op);
        longint ua = a;
        longint ub = b;
        longint sa = (ua >= HALF) ? ua - FULL : ua;
        longint sb = (ub >= HALF) ? ub - FULL : ub;
        longint r = 0;
        logic c = 1'b0;
        logic o = 1'b0;
        case (op)
            3'd0: r = ua & ub;
            3'd1: r = ua | ub;
            3'd3: r = ua ^ ub;
            3'd2: begin
                r = ua + ub;
                c = (r >= FULL);
                o = (sa + sb > HALF - 1) || (sa + sb < -HALF);
                r = r % FULL;
            end
            3'd6: begin
                r = (ua - ub + FULL) % FULL;
                c = (ua < ub);
                o = (sa - sb > HALF - 1) || (sa - sb < -HALF);
            end
            3'd7: r = (ua < ub) ? 1 : 0;
            3'd4: r = (ub >= W) ? 0 : (ua << ub) % FULL;
`ifdef SEQ_ALU_MUL_EN
            3'd5: r = (ua * ub) % FULL;
`endif
            default: r = 0;
        endcase
        return {o, c, r[W-1:0]};
    endfunction

    function automatic int extra_cycles(input logic [2:0] op);
`ifdef SEQ_ALU_MUL_EN
        return (op == 3'd5) ? W : 0;
`else
        return 0;
`endif
    endfunction

    // model: 0 idle, 1 computing, 2 result presented
    int           m_phase = 0;
    int           m_left = 0;
    logic [W-1:0] m_res = '0;
    logic         m_c = 1'b0;
    logic         m_o = 1'b0;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (valid_i) begin
                    {m_o, m_c, m_res} = model(a_i, b_i, operation_i);
                    m_left = extra_cycles(operation_i);
                    m_phase = (m_left > 0) ? 1 : 2;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (ready_i) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            chk("rst_ready", ready_o, 1);
            chk("rst_valid", valid_o, 0);
            chk("rst_result", result_o, 0);
            chk("rst_flags", {zero_o, carry_o, overflow_o}, 3'b100);
        end else begin
            chk("ready", ready_o, (m_phase == 0) ? 1 : 0);
            chk("valid", valid_o, (m_phase == 2) ? 1 : 0);
            if (m_phase == 2) begin
                chk("result", result_o, m_res);
                chk("zero", zero_o, (m_res == 0) ? 1 : 0);
                chk("carry", carry_o, m_c);
                chk("overflow", overflow_o, m_o);
            end
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input int hold,
                         input bit pre, output logic [W-1:0] r,
                         output logic [2:0] zco, output int lat);
        int n;
        n = 0;
        while (!ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!ready_o) begin
            n_checks++; n_err++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
        valid_i = 1'b1; a_i = a; b_i = b; operation_i = op;
        ready_i = pre;
        @(negedge clk_i);
        valid_i = 1'b0;
        a_i = W'($urandom); b_i = W'($urandom);
        operation_i = 3'($urandom);
        n = 0;
        while (!valid_o && n < 50) begin
            if (!pre) valid_i = 1'($urandom);
            @(negedge clk_i);
            n++;
        end
        if (!valid_o) begin
            n_checks++; n_err++;
            $display("FAIL valid_timeout: got 0 expected 1");
        end
        r = result_o;
        zco = {zero_o, carry_o, overflow_o};
        lat = n + 1;
        if (!pre) begin
            repeat (hold) begin
                valid_i = 1'($urandom);
                a_i = W'($urandom); b_i = W'($urandom);
                @(negedge clk_i);
            end
            ready_i = 1'b1;
            valid_i = 1'b0;
        end
        @(negedge clk_i);
        ready_i = 1'b0;
        valid_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r;
        logic [2:0]   zco;
        int           lat;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2:0]   rop;

        chk("model_add", model(8'hFF, 8'h01, 3'd2), 10'b01_0000_0000);
        chk("model_sub", model(8'h03, 8'h05, 3'd6), 10'b01_1111_1110);
        chk("model_sll", model(8'h11, 8'h03, 3'd4), 10'b00_1000_1000);

        repeat (3) @(negedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);

        do_op(8'hFF, 8'h01, 3'd2, 0, 1'b1, r, zco, lat);
        chk("add_ff_res", r, 8'h00);
        chk("add_ff_zco", zco, 3'b110);
        chk("add_ff_lat", lat, 1);

        do_op(8'h7F, 8'h01, 3'd2, 1, 1'b0, r, zco, lat);
        chk("add_7f_res", r, 8'h80);
        chk("add_7f_zco", zco, 3'b001);

        do_op(8'h03, 8'h05, 3'd6, 0, 1'b0, r, zco, lat);
        chk("sub_res", r, 8'hFE);
        chk("sub_zco", zco, 3'b010);

        do_op(8'h0C, 8'h0B, 3'd5, 2, 1'b0, r, zco, lat);
`ifdef SEQ_ALU_MUL_EN
        chk("mul_res", r, 8'h84);
        chk("mul_lat", lat, 9);
        chk("mul_zco", zco, 3'b000);
`else
        chk("mul_res", r, 8'h00);
        chk("mul_lat", lat, 1);
        chk("mul_zco", zco, 3'b100);
`endif

        do_op(8'h02, 8'h09, 3'd7, 5, 1'b0, r, zco, lat);
        chk("slt_res", r, 8'h01);
        chk("slt_idle", ready_o, 1);

        do_op(8'h01, 8'h07, 3'd4, 0, 1'b1, r, zco, lat);
        chk("sll7_res", r, 8'h80);
        do_op(8'h01, 8'h08, 3'd4, 0, 1'b1, r, zco, lat);
        chk("sll8_res", r, 8'h00);
        chk("sll8_zero", zco[2], 1);
        do_op(8'h11, 8'h03, 3'd4, 0, 1'b1, r, zco, lat);
        chk("sll3_res", r, 8'h88);

        // reset in the middle of a multiply
        valid_i = 1'b1; a_i = 8'h0C; b_i = 8'h0B; operation_i = 3'd5;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        chk("mrst_ready", ready_o, 1);
        chk("mrst_valid", valid_o, 0);
        chk("mrst_result", result_o, 0);
        chk("mrst_flags", {zero_o, carry_o, overflow_o}, 3'b100);
        @(negedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (W + 3) begin
            @(negedge clk_i);
            chk("mrst_novalid", valid_o, 0);
        end

        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rop = 3'($urandom_range(0, 7));
            if (rop == 3'd4 && $urandom_range(0, 1) == 1)
                rb = W'($urandom_range(0, 10));
            do_op(ra, rb, rop, $urandom_range(0, 3),
                  1'($urandom), r, zco, lat);
            chk("rand_lat", lat, extra_cycles(rop) + 1);
        end

        repeat (2) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; legal range 4..32.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port valid_i  input  1  request valid.
REQ-005 SHALL have port ready_o  output  1  block can accept a request.
REQ-006 SHALL have port a_i  input  WIDTH  first operand.
REQ-007 SHALL have port b_i  input  WIDTH  second operand.
REQ-008 SHALL have port operation_i  input  3  operation code.
REQ-009 SHALL have port valid_o  output  1  result valid.
REQ-010 SHALL have port ready_i  input  1  consumer accepts result.
REQ-011 SHALL have port result_o  output  WIDTH  result.
REQ-012 SHALL have port zero_o  output  1  result_o equals zero.
REQ-013 SHALL have port carry_o  output  1  ADD carry-out / SUB borrow.
REQ-014 SHALL have port overflow_o  output  1  signed overflow of ADD/SUB.

Function
REQ-015 SHALL implement three states: IDLE, BUSY, DONE; ready_o = 1 only in IDLE; valid_o = 1 only in DONE.
REQ-016 SHALL accept a request on a clock edge with valid_i=1 and ready_o=1, capturing a_i, b_i and operation_i in that edge.
REQ-017 Opcodes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (unsigned, result 1 or 0), 011 XOR, 100 SLL, 101 MUL; other values none.
REQ-018 Single-cycle ops (all except MUL): IDLE->DONE on accept; valid_o high the cycle after accept.
REQ-019 MUL: IDLE->BUSY on accept; shift-add, one multiplier bit per cycle, WIDTH cycles in BUSY, then DONE; valid_o high WIDTH+1 cycles after accept.
REQ-020 MUL result = low WIDTH bits of unsigned a*b; carry_o=0, overflow_o=0.
REQ-021 ADD: result = (a+b) mod 2^WIDTH; carry_o = bit WIDTH of the sum.
REQ-022 SUB: result = (a-b) mod 2^WIDTH; carry_o = 1 iff a<b unsigned.
REQ-023 overflow_o for ADD/SUB = signed two's-complement overflow; 0 for every other op.
REQ-024 SLL: shift a left by b; b >= WIDTH yields result 0.
REQ-025 carry_o = 0 for all ops except ADD/SUB.
REQ-026 zero_o = (result_o == 0), valid with valid_o.
REQ-027 DONE: result_o and flags held stable while valid_o=1 and ready_i=0; DONE->IDLE on edge with ready_i=1.
REQ-028 valid_i while ready_o=0 SHALL be ignored; inputs changing during BUSY/DONE SHALL not affect the result in flight.
REQ-029 Max throughput: one single-cycle op per 2 cycles (no accept in DONE).

Reset
REQ-030 rst_ni low SHALL immediately force IDLE, ready_o=1, valid_o=0, result_o=0, zero_o=1, carry_o=0, overflow_o=0.
REQ-031 Reset during BUSY or DONE SHALL discard the operation in flight; no valid_o follows it.

Configuration
REQ-032 Macro SEQ_ALU_MUL_EN SHALL control the multiplier.
REQ-033 With SEQ_ALU_MUL_EN defined: MUL per REQ-019/020; BUSY state exists.
REQ-034 Without it: opcode 101 SHALL behave as an unsupported op -- single-cycle, result 0, zero_o=1, carry_o=0, overflow_o=0; no multiplier logic or BUSY state.

Verification (WIDTH=8)
REQ-035 ADD a=0xFF b=0x01, ready_i=1 -> valid_o next cycle, result 0x00, zero_o=1, carry_o=1, overflow_o=0.
REQ-036 ADD a=0x7F b=0x01 -> result 0x80, overflow_o=1, carry_o=0; SUB a=0x03 b=0x05 -> 0xFE, carry_o=1.
REQ-037 MUL a=0x0C b=0x0B (macro on) -> ready_o low 9 cycles, valid_o 9 cycles after accept, result 0x84; macro off -> result 0x00 next cycle.
REQ-038 SLT a=0x02 b=0x09 with ready_i=0 for 5 cycles -> result 0x01 held 5 cycles, valid_i during hold ignored; ready_i=1 -> IDLE next cycle.
REQ-039 SLL a=0x01 b=0x07 -> 0x80; b=0x08 -> 0x00, zero_o=1; opcode 100 with b=0x03 a=0x11 -> 0x88.
REQ-040 rst_ni low mid-MUL (cycle 4 of BUSY) -> outputs at reset values at once, ready_o=1 after release, no valid_o.
